// File: rtl/text_cell_buffer.sv
// Character-cell frame buffer for the VGA text renderer: console write stream with
// cursor, wrap, circular-row scroll and clear; registered read port for the display.
module text_cell_buffer #(
    parameter int          COLS  = 40,
    parameter int          ROWS  = 25,
    parameter logic [15:0] BLANK = 16'h0020
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ch_data,
    input  logic        ch_valid,
    output logic        ch_ready,
    input  logic [5:0]  rd_col,
    input  logic [4:0]  rd_row,
    output logic [15:0] code_out,
    output logic [5:0]  cur_col,
    output logic [4:0]  cur_row,
    output logic        busy
);

    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [5:0] COLS6    = 6'(COLS);
    localparam logic [5:0] ROWS6    = 6'(ROWS);

    typedef enum logic [1:0] {IDLE, CLEAR_ROW, CLEAR_ALL} state_t;

    state_t      state, state_n;
    logic [4:0]  top, top_n;
    logic [5:0]  col_n;
    logic [4:0]  row_n;
    logic [5:0]  clr_col, clr_col_n;
    logic [4:0]  clr_row, clr_row_n;
    logic        we;
    logic [10:0] waddr;
    logic [15:0] wdata;
    logic        accept;
    logic        line_feed;
    logic        rd_in_range;
    logic [10:0] raddr;

    logic [15:0] mem [0:2047];

    // Logical row to physical row through the circular top pointer.
    function automatic logic [4:0] phys_row(input logic [4:0] lrow, input logic [4:0] t);
        logic [5:0] s;
        s = {1'b0, lrow} + {1'b0, t};
        if (s >= ROWS6)
            s = s - ROWS6;
        return 5'(s);
    endfunction

    assign ch_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = ch_valid && ch_ready;

    always_comb begin
        state_n   = state;
        top_n     = top;
        col_n     = cur_col;
        row_n     = cur_row;
        clr_col_n = clr_col;
        clr_row_n = clr_row;
        we        = 1'b0;
        waddr     = '0;
        wdata     = BLANK;
        line_feed = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (ch_data)
                        16'h000A: begin
                            col_n     = '0;
                            line_feed = 1'b1;
                        end
                        16'h000D: col_n = '0;
                        16'h0008: begin
                            if (cur_col != '0) begin
                                col_n = cur_col - 6'd1;
                                we    = 1'b1;
                                waddr = {phys_row(cur_row, top), cur_col - 6'd1};
                            end else if (cur_row != '0) begin
                                row_n = cur_row - 5'd1;
                                col_n = LAST_COL;
                                we    = 1'b1;
                                waddr = {phys_row(cur_row - 5'd1, top), LAST_COL};
                            end
                        end
                        16'h000C: begin
                            state_n   = CLEAR_ALL;
                            clr_col_n = '0;
                            clr_row_n = '0;
                        end
                        default: begin
                            we    = 1'b1;
                            waddr = {phys_row(cur_row, top), cur_col};
                            wdata = ch_data;
                            if (cur_col != LAST_COL) begin
                                col_n = cur_col + 6'd1;
                            end else begin
                                col_n     = '0;
                                line_feed = 1'b1;
                            end
                        end
                    endcase
                    // Shared row advance for newline and wrap; last row scrolls instead.
                    if (line_feed) begin
                        if (cur_row != LAST_ROW) begin
                            row_n = cur_row + 5'd1;
                        end else begin
                            clr_row_n = top;
                            clr_col_n = '0;
                            top_n     = (top == LAST_ROW) ? '0 : top + 5'd1;
                            state_n   = CLEAR_ROW;
                        end
                    end
                end
            end
            CLEAR_ROW: begin
                we    = 1'b1;
                waddr = {clr_row, clr_col};
                if (clr_col == LAST_COL)
                    state_n = IDLE;
                else
                    clr_col_n = clr_col + 6'd1;
            end
            CLEAR_ALL: begin
                we    = 1'b1;
                waddr = {clr_row, clr_col};
                if (clr_col == LAST_COL) begin
                    clr_col_n = '0;
                    if (clr_row == LAST_ROW) begin
                        state_n = IDLE;
                        top_n   = '0;
                        col_n   = '0;
                        row_n   = '0;
                    end else begin
                        clr_row_n = clr_row + 5'd1;
                    end
                end else begin
                    clr_col_n = clr_col + 6'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR_ALL;
            top     <= '0;
            cur_col <= '0;
            cur_row <= '0;
            clr_col <= '0;
            clr_row <= '0;
        end else begin
            state   <= state_n;
            top     <= top_n;
            cur_col <= col_n;
            cur_row <= row_n;
            clr_col <= clr_col_n;
            clr_row <= clr_row_n;
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rd_in_range = (rd_col < COLS6) && (rd_row < LAST_ROW + 5'd1);
    assign raddr       = {phys_row(rd_row, top), rd_col};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            code_out <= '0;
        else if (!rd_in_range)
            code_out <= BLANK;
        else
            code_out <= mem[raddr];
    end

endmodule
